// File: rtl/gfp_alu.sv
// GF(p) arithmetic unit: modular add, sub, mul (MSB-first double-and-add) and
// divide (binary extended Euclid), with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module gfp_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(4*WIDTH+4)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err,
    output logic             o_busy
);
    typedef enum logic [2:0] {
        IDLE, ADD, SUB, RED, MUL, INV, DONE
    } state_t;

    localparam logic [CNT_W-1:0] MUL_FIRST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] INV_LIMIT = CNT_W'(4*WIDTH + 1);

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, y, m);
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        return WIDTH'(t);
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, y, m);
        logic [WIDTH:0] t;
        t = {1'b0, x} - {1'b0, y};
        if (x < y) t = t + {1'b0, m};
        return WIDTH'(t);
    endfunction

    // Halving mod an odd m: an odd x becomes even by adding m first.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x, m);
        logic [WIDTH:0] t;
        t = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
        return WIDTH'(t >> 1);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d, valid_q, valid_d;

    logic [WIDTH-1:0] r_dbl, r_acc;
    logic [WIDTH:0]   s_red;

    assign r_dbl = add_mod(s_q[WIDTH-1:0], s_q[WIDTH-1:0], p_q);
    assign r_acc = a_q[WIDTH-1] ? add_mod(r_dbl, b_q, p_q) : r_dbl;
    assign s_red = (s_q >= {1'b0, p_q}) ? s_q - {1'b0, p_q} : s_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        s_d      = s_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: if (i_valid) begin
                a_d   = i_a;
                b_d   = i_b;
                p_d   = i_p;
                s_d   = '0;
                u_d   = i_b;
                v_d   = i_p;
                x1_d  = i_a;
                x2_d  = '0;
                cnt_d = (i_op == 2'd2) ? MUL_FIRST : '0;
                err_d = 1'b0;
                case (i_op)
                    2'd0:    state_d = ADD;
                    2'd1:    state_d = SUB;
                    2'd2:    state_d = MUL;
                    default: state_d = INV;
                endcase
            end
            ADD: begin
                s_d     = {1'b0, a_q} + {1'b0, b_q};
                state_d = RED;
            end
            SUB: begin
                s_d     = {1'b0, sub_mod(a_q, b_q, p_q)};
                state_d = RED;
            end
            RED: begin
                result_d = WIDTH'(s_red);
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            // The finished product goes through RED so it lands on the same
            // result-load path as add/sub; it is already below p.
            MUL: begin
                s_d   = {1'b0, r_acc};
                a_d   = a_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = RED;
            end
            INV: begin
                cnt_d = cnt_q + 1'b1;
                if (u_q == '0 || cnt_q == INV_LIMIT) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (u_q == WIDTH'(1)) begin
                    result_d = x1_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (v_q == WIDTH'(1)) begin
                    result_d = x2_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q, p_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q, p_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q, p_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q, p_q);
                end
            end
            DONE: if (i_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            s_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            s_q      <= s_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == IDLE) & ~i_rst;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_gfp_alu.sv
// Scoreboard bench for gfp_alu: expected results are queued at accept and
// compared at the result handshake, along with the o_valid latency.
`timescale 1ns/1ps
module tb_gfp_alu;
    localparam int          WIDTH   = 32;
    localparam int          CNT_W   = $clog2(4*WIDTH+4);
    localparam logic [31:0] P_SMALL = 32'd97;
    localparam logic [31:0] P_BIG   = 32'd4294967291;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b1;
    logic [1:0]       i_op = '0;
    logic [WIDTH-1:0] i_a = '0, i_b = '0, i_p = '0;
    logic             o_ready, o_valid, o_err, o_busy;
    logic [WIDTH-1:0] o_result;

    gfp_alu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_p(i_p),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] res;
        logic             err;
        int               acc_edge;
        int               lat;
        bit               exact;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit modular arithmetic, division via Fermat b^(p-2).
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, b, p);
        logic [63:0] aa, bb, pp, e, acc, base;
        logic [32:0] res;
        aa = 64'(a);
        bb = 64'(b);
        pp = 64'(p);
        res = '0;
        case (op)
            2'd0: res = {1'b0, 32'((aa + bb) % pp)};
            2'd1: res = {1'b0, 32'((aa + pp - bb) % pp)};
            2'd2: res = {1'b0, 32'((aa * bb) % pp)};
            default: begin
                if (b == '0) begin
                    res = {1'b1, 32'd0};
                end else begin
                    e    = pp - 64'd2;
                    acc  = 64'd1;
                    base = bb;
                    for (int i = 0; i < 32; i++) begin
                        if (e[i]) acc = (acc * base) % pp;
                        base = (base * base) % pp;
                    end
                    res = {1'b0, 32'((aa * acc) % pp)};
                end
            end
        endcase
        return res;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin : monitor
        exp_t e;
        int   lat;
        if (i_valid && o_ready) begin
            e          = pend;
            e.acc_edge = cyc + 1;
            sb.push_back(e);
        end
        if (o_valid && !valid_prev && sb.size() > 0) begin
            lat = cyc - sb[0].acc_edge;
            if (sb[0].exact) check({sb[0].name, "_latency"}, lat, sb[0].lat);
            else check({sb[0].name, "_latency_max"}, (lat > sb[0].lat) ? lat : sb[0].lat, sb[0].lat);
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("spurious_valid", o_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, o_result, e.res);
                check({e.name, "_err"}, o_err, e.err);
            end
        end
        valid_prev = o_valid;
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a, b, p,
                         input logic [31:0] exp_res, input logic exp_err);
        bit ok;
        @(posedge i_clk); #2;
        pend.name = name;
        pend.res  = exp_res;
        pend.err  = exp_err;
        if (op == 2'd3 && b == '0) begin
            pend.lat = 1; pend.exact = 1'b1;
        end else if (op == 2'd3) begin
            pend.lat = 4*WIDTH + 2; pend.exact = 1'b0;
        end else if (op == 2'd2) begin
            pend.lat = WIDTH + 1; pend.exact = 1'b1;
        end else begin
            pend.lat = 2; pend.exact = 1'b1;
        end
        i_op = op; i_a = a; i_b = b; i_p = p;
        i_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge i_clk);
            ok = o_ready;
        end
        @(posedge i_clk); #2;
        i_valid = 1'b0;
        check({name, "_accepted"}, ok, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check({name, "_completed"}, sb.size(), 0);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, b, p,
                         input logic [31:0] exp_res, input logic exp_err);
        issue(name, op, a, b, p, exp_res, exp_err);
        wait_done(name);
    endtask

    initial begin
        logic [32:0] m;
        logic [31:0] p, a, b;
        logic [1:0]  op;
        int          n;

        @(negedge i_clk);
        check("reset_valid", o_valid, 1'b0);
        check("reset_result", o_result, 0);
        check("reset_err", o_err, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_ready", o_ready, 1'b0);
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;

        do_op("add_60_50", 2'd0, 60, 50, P_SMALL, 13, 1'b0);
        do_op("sub_5_20", 2'd1, 5, 20, P_SMALL, 82, 1'b0);
        do_op("mul_45_77", 2'd2, 45, 77, P_SMALL, 70, 1'b0);
        do_op("div_1_3", 2'd3, 1, 3, P_SMALL, 65, 1'b0);
        do_op("div_0_5", 2'd3, 0, 5, P_SMALL, 0, 1'b0);
        do_op("div_7_0", 2'd3, 7, 0, P_SMALL, 0, 1'b1);
        do_op("big_add", 2'd0, P_BIG - 1, P_BIG - 1, P_BIG, 32'd4294967289, 1'b0);
        do_op("big_mul", 2'd2, P_BIG - 1, P_BIG - 1, P_BIG, 1, 1'b0);
        do_op("big_div", 2'd3, P_BIG - 1, P_BIG - 1, P_BIG, 1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            p  = k[0] ? P_BIG : P_SMALL;
            op = 2'($urandom_range(0, 3));
            a  = $urandom % p;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom % p;
            m  = model(op, a, b, p);
            do_op($sformatf("rand%0d_op%0d", k, op), op, a, b, p, m[31:0], m[32]);
        end

        i_ready = 1'b0;
        issue("bp_mul", 2'd2, 45, 77, P_SMALL, 70, 1'b0);
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("bp_valid_seen", o_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #2;
            i_valid = 1'b1; i_op = 2'd0; i_a = 1; i_b = 1; i_p = P_SMALL;
            @(negedge i_clk);
            check("bp_hold_valid", o_valid, 1'b1);
            check("bp_hold_result", o_result, 70);
            check("bp_hold_err", o_err, 1'b0);
            check("bp_hold_ready", o_ready, 1'b0);
        end
        @(posedge i_clk); #2;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("bp_ready_after", o_ready, 1'b1);
        check("bp_valid_after", o_valid, 1'b0);
        check("bp_queue_empty", sb.size(), 0);

        issue("rst_mul", 2'd2, 45, 77, P_SMALL, 70, 1'b0);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_busy_before", o_busy, 1'b1);
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        sb.delete();
        @(negedge i_clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_result", o_result, 0);
        check("rst_err", o_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", o_ready, 1'b0);
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready_after", o_ready, 1'b1);
        check("rst_no_stale_valid", o_valid, 1'b0);
        do_op("post_rst_add", 2'd0, 1, 1, P_SMALL, 2, 1'b0);

        repeat (3) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gfp_alu.md
# gfp_alu

Parametrised GF(p) arithmetic unit for the ECC datapath. It computes modular add, subtract, multiply and divide (a·b⁻¹ mod p) on WIDTH-bit operands. Valid/ready handshakes on both the command and result sides let the point-arithmetic controller stall either side. It replaces the fixed 32-bit, single-pulse unit: true (non-Montgomery) products, divide-by-zero error reporting and result backpressure are new.

## Interface
- WIDTH, 32, operand/prime width in bits (≥ 8)
- CNT_W, $clog2(4*WIDTH+4), width of internal iteration counter

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  command valid
- o_ready  out  1  unit idle, command accepted when i_valid & o_ready
- i_op  in  2  0 add, 1 sub, 2 mul, 3 div
- i_a  in  WIDTH  operand a (dividend for div)
- i_b  in  WIDTH  operand b (divisor for div)
- i_p  in  WIDTH  odd prime modulus
- o_valid  out  1  result valid, held until consumed
- i_ready  in  1  consumer accepts result when o_valid & i_ready
- o_result  out  WIDTH  result in [0, p-1]
- o_err  out  1  divide by zero; qualified by o_valid
- o_busy  out  1  operation in progress (not IDLE, not DONE)

## Operation
- Preconditions: 3 ≤ p < 2^WIDTH, p odd prime, a < p, b < p. If a precondition is violated, the result is undefined, but the handshake still completes within the latency bound.
- Accept latches i_op, i_a, i_b and i_p. Inputs are ignored afterwards.
- States: IDLE, ADD, SUB, RED, MUL, INV, DONE.
- IDLE: o_ready=1. On accept:
  - add → ADD, sub → SUB, mul → MUL, div → INV.
  - div with b==0 → DONE directly, with o_err=1 and o_result=0.
- ADD: s = a+b computed at WIDTH+1 bits → RED.
- SUB: s = a−b if a≥b, else a−b+p → RED.
- RED: if s ≥ p then s−p (compare is ≥, not >) → DONE.
- MUL: MSB-first double-and-add with r starting at 0. Each cycle, for bit i = WIDTH−1 down to 0:
  - r = 2r mod p
  - then, if a[i], r = r+b mod p
  - all intermediates WIDTH+1 bits, each step reduced by a single conditional subtract
  - after bit 0 → DONE
- INV: binary extended Euclid, starting u=b, v=p, x1=a, x2=0. Exactly one action per cycle, in priority order:
  - u==1 → result x1 → DONE
  - v==1 → result x2 → DONE
  - u even → u>>=1; x1 = x1 even ? x1>>1 : (x1+p)>>1, sum at WIDTH+1 bits
  - v even → same on v, x2
  - u ≥ v → u−=v, x1 = x1−x2 mod p
  - else → v−=u, x2 = x2−x1 mod p
- DONE: o_valid=1 with o_result and o_err stable. On i_valid... no: on o_valid & i_ready → IDLE and o_valid=0.
- o_err is cleared on the next accept.

## Timing
- Reset values: o_valid=0, o_result=0, o_err=0, o_busy=0, state IDLE.
- o_ready = (state==IDLE) & ~i_rst, so o_ready is 0 while reset is held.
- Edge 0 is the accepting edge. o_valid rises at:
  - add/sub: edge 2
  - mul: edge WIDTH+1
  - div: edge ≤ 4·WIDTH+2
  - div with b==0: edge 1
- A new command can be accepted no earlier than the edge after the result handshake. There is no accept in the same cycle as o_valid & i_ready, because o_ready is 0 in DONE.
- o_valid and o_result are registered. There are no combinational paths from i_* to o_valid or o_result.
- i_ready low in DONE: outputs are held indefinitely.
- Reset mid-operation: the unit returns to IDLE immediately (async). The partial result is discarded and no o_valid is emitted.
- The iteration counter saturates in INV. If the bound 4·WIDTH+2 is reached without u==1 or v==1 (precondition violated), the unit forces DONE with o_result=0 and o_err=1.

## Test plan
- WIDTH=32, p=97:
  - add 60,50 → 13, o_valid at edge 2
  - sub 5,20 → 82
- p=97, mul 45,77 → 70, o_valid exactly at edge 33.
- p=97, div 1,3 → 65. Then div 0,5 → 0 with o_err=0. Then div 7,0 → o_err=1, o_result=0 at edge 1.
- p=4294967291:
  - add p−1,p−1 → 4294967289, exercising the WIDTH+1 carry
  - mul p−1,p−1 → 1
  - div p−1,p−1 → 1
- Backpressure: mul completes while i_ready is held low for 5 cycles. o_valid, o_result and o_err must stay stable, o_ready=0 and i_valid is ignored. Release i_ready: o_ready=1 the next cycle.
- Assert i_rst at edge 10 of a mul. All outputs return to reset values. After release, add 1,1 with p=97 → 2, with no stale o_valid.
